// File: rtl/garbage_inserter.sv
// Garbage-row inserter: pushes up to MAX_LINES garbage rows in from the bottom, one row per cycle.
// Optional build macro GARBAGE_SAME_HOLE_EN: one hole column shared by every row of a batch.
`ifndef FIELD_VERTICAL
`define FIELD_VERTICAL 20
`endif
`ifndef FIELD_HORIZONTAL
`define FIELD_HORIZONTAL 10
`endif
`ifndef TETROMINO_EMPTY
`define TETROMINO_EMPTY 3'd0
`endif

package gi_pkg;
    localparam int FV = `FIELD_VERTICAL;
    localparam int FH = `FIELD_HORIZONTAL;
    localparam logic [2:0] CELL_EMPTY = `TETROMINO_EMPTY;
    typedef struct packed {
        logic [2:0] data;
    } cell_t;
    typedef cell_t [FV-1:0][FH-1:0] field_t;
endpackage

// state  | meaning
// IDLE   | waiting for start; f_out holds the last result
// SHIFT  | one garbage row pushed in per cycle
// FINISH | f_out valid, done pulse
module garbage_inserter
    import gi_pkg::*;
#(
    parameter logic [2:0] GARBAGE_CODE = 3'd7,
    parameter logic [7:0] LFSR_SEED    = 8'hA5,
    parameter int         MAX_LINES    = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [2:0]   n_lines,
    input  field_t       f_in,
    output field_t       f_out,
    output logic         busy,
    output logic         done,
    output logic         topped_out,
    output logic [3:0]   hole_col
);

    typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

    state_t      state_q, state_d;
    field_t      f_temp_q, f_temp_d;
    field_t      f_out_q, f_out_d;
    logic [2:0]  remaining_q, remaining_d;
    logic [7:0]  lfsr_q, lfsr_d;
    logic        topped_q, topped_d;
    logic [3:0]  hole_q, hole_d;
`ifdef GARBAGE_SAME_HOLE_EN
    logic [3:0]  batch_hole_q, batch_hole_d;
`endif

    logic [7:0]  lfsr_adv;
    logic [3:0]  lfsr_hole;
    logic [3:0]  row_hole;
    logic [2:0]  n_clamped;
    logic        row0_occupied;

    always_comb begin
        lfsr_adv  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        lfsr_hole = 4'(int'(lfsr_q[3:0]) % FH);
        n_clamped = (int'(n_lines) > MAX_LINES) ? 3'(MAX_LINES) : n_lines;
`ifdef GARBAGE_SAME_HOLE_EN
        row_hole  = batch_hole_q;
`else
        row_hole  = lfsr_hole;
`endif
        row0_occupied = 1'b0;
        for (int c = 0; c < FH; c++) begin
            if (f_temp_q[0][c].data != CELL_EMPTY) row0_occupied = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        f_temp_d    = f_temp_q;
        f_out_d     = f_out_q;
        remaining_d = remaining_q;
        lfsr_d      = lfsr_q;
        topped_d    = topped_q;
        hole_d      = hole_q;
`ifdef GARBAGE_SAME_HOLE_EN
        batch_hole_d = batch_hole_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    f_temp_d    = f_in;
                    remaining_d = n_clamped;
                    topped_d    = 1'b0;
                    state_d     = (n_clamped == 3'd0) ? FINISH : SHIFT;
`ifdef GARBAGE_SAME_HOLE_EN
                    lfsr_d       = lfsr_adv;
                    batch_hole_d = lfsr_hole;
`endif
                end
            end
            SHIFT: begin
                if (row0_occupied) topped_d = 1'b1;
                for (int k = 0; k < FV-1; k++) f_temp_d[k] = f_temp_q[k+1];
                for (int c = 0; c < FH; c++) begin
                    f_temp_d[FV-1][c].data = (c == int'(row_hole)) ? CELL_EMPTY : GARBAGE_CODE;
                end
                hole_d = row_hole;
`ifndef GARBAGE_SAME_HOLE_EN
                lfsr_d = lfsr_adv;
`endif
                remaining_d = remaining_q - 3'd1;
                if (remaining_q == 3'd1) state_d = FINISH;
            end
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // f_out is loaded on the edge entering FINISH so it is already valid while done is high
        if (state_d == FINISH && state_q != FINISH) f_out_d = f_temp_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            f_temp_q    <= '0;
            f_out_q     <= {(FV*FH){CELL_EMPTY}};
            remaining_q <= 3'd0;
            lfsr_q      <= LFSR_SEED;
            topped_q    <= 1'b0;
            hole_q      <= 4'd0;
`ifdef GARBAGE_SAME_HOLE_EN
            batch_hole_q <= 4'd0;
`endif
        end else begin
            state_q     <= state_d;
            f_temp_q    <= f_temp_d;
            f_out_q     <= f_out_d;
            remaining_q <= remaining_d;
            lfsr_q      <= lfsr_d;
            topped_q    <= topped_d;
            hole_q      <= hole_d;
`ifdef GARBAGE_SAME_HOLE_EN
            batch_hole_q <= batch_hole_d;
`endif
        end
    end

    assign f_out      = f_out_q;
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == FINISH);
    assign topped_out = topped_q;
    assign hole_col   = hole_q;

endmodule
